// File: rtl/vga_timing_pkg.sv
// VGA 640x480 timing constants and monitor types.
// Shared by the loopback receiver and its edge detectors.
package vga_timing_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam int ERR_HSW   = 0;
  localparam int ERR_LINE  = 1;
  localparam int ERR_FRAME = 2;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } mon_state_e;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_START,
    EDGE_END
  } sync_edge_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Sync polarity normalisation with start/end strobes,
// evaluated only on pixel-enable samples.
module sync_edge_detect
  import vga_timing_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       sync_in,
  output sync_edge_e ev
);

  logic level;
  logic prev;

  assign level = sync_in ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset)
      prev <= 1'b0;
    else if (pix_en)
      prev <= level;
  end

  always_comb begin
    ev = EDGE_NONE;
    if (pix_en && level && !prev)
      ev = EDGE_START;
    else if (pix_en && !level && prev)
      ev = EDGE_END;
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA loopback monitor: recovers coordinates from sync,
// checks timing, sums visible pixels and captures a probe.
module vga_rx_monitor #(
  parameter int H_VIS  = vga_timing_pkg::H_VIS,
  parameter int H_FP   = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP   = vga_timing_pkg::H_BP,
  parameter int V_VIS  = vga_timing_pkg::V_VIS,
  parameter int V_FP   = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP   = vga_timing_pkg::V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        HS,
  input  logic        VS,
  input  logic [11:0] vgaRGB,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [11:0] rx_rgb,
  output logic        rx_valid,
  output logic        locked,
  output logic        frame_done,
  output logic [23:0] frame_checksum,
  output logic        frame_ok,
  output logic [2:0]  err_flags,
  output logic [7:0]  err_count,
  output logic [11:0] probe_rgb,
  output logic        probe_hit
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_ST  = H_SYNC + H_BP;
  localparam int V_ST  = V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0]  H_SW   = 10'(H_SYNC - 1);
  localparam logic [9:0]  H_LO   = 10'(H_ST);
  localparam logic [9:0]  H_HI   = 10'(H_ST + H_VIS);
  localparam logic [9:0]  V_LO   = 10'(V_ST);
  localparam logic [9:0]  V_HI   = 10'(V_ST + V_VIS);
  localparam logic [10:0] V_LEN  = 11'(V_TOT);

  sync_edge_e hs_ev;
  sync_edge_e vs_ev;

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs (
    .clk     (clk),
    .reset   (reset),
    .pix_en  (pix_en),
    .sync_in (HS),
    .ev      (hs_ev)
  );

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs (
    .clk     (clk),
    .reset   (reset),
    .pix_en  (pix_en),
    .sync_in (VS),
    .ev      (vs_ev)
  );

  mon_state_e  state;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [23:0] acc;
  logic        first_line;

  logic        hs_start;
  logic        hs_end;
  logic        vs_start;
  logic        active;
  logic        vis;
  logic        hit;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [9:0]  vx;
  logic [9:0]  vy;
  logic        line_err;
  logic        hsw_err;
  logic        frame_err;
  logic        any_err;
  logic        frame_end;

  always_comb begin
    hs_start = (hs_ev == EDGE_START);
    hs_end   = (hs_ev == EDGE_END);
    vs_start = (vs_ev == EDGE_START);
    active   = (state != SEARCH);
    h_nxt    = hs_start ? 10'd0 : h_cnt + 10'd1;
    v_nxt    = vs_start ? 10'd0 :
               hs_start ? v_cnt + 10'd1 : v_cnt;
    vx       = h_nxt - H_LO;
    vy       = v_nxt - V_LO;
    vis      = pix_en && active &&
               h_nxt >= H_LO && h_nxt < H_HI &&
               v_nxt >= V_LO && v_nxt < V_HI;
    hit      = vis && vx == probe_x && vy == probe_y;
    // A line running past H_TOT without HS is caught at once.
    line_err = active &&
               ((hs_start && h_cnt != H_LAST &&
                 !(state == ACQUIRE && first_line)) ||
                (pix_en && !hs_start && h_cnt == H_LAST));
    hsw_err  = active && hs_end && h_cnt != H_SW;
    frame_err = active && vs_start &&
                ({1'b0, v_cnt} + {10'd0, hs_start}) != V_LEN;
    any_err   = line_err || hsw_err || frame_err;
    frame_end = active && vs_start && !any_err;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SEARCH;
      h_cnt          <= '0;
      v_cnt          <= '0;
      acc            <= '0;
      first_line     <= 1'b0;
      rx_x           <= '0;
      rx_y           <= '0;
      rx_rgb         <= '0;
      rx_valid       <= 1'b0;
      frame_done     <= 1'b0;
      frame_checksum <= '0;
      frame_ok       <= 1'b0;
      err_flags      <= '0;
      err_count      <= '0;
      probe_rgb      <= '0;
      probe_hit      <= 1'b0;
    end else begin
      rx_valid   <= vis;
      probe_hit  <= hit;
      frame_done <= frame_end;
      if (vis) begin
        rx_x   <= vx;
        rx_y   <= vy;
        rx_rgb <= vgaRGB;
      end
      if (hit)
        probe_rgb <= vgaRGB;
      if (pix_en) begin
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        if (vs_start)
          first_line <= 1'b1;
        else if (hs_start)
          first_line <= 1'b0;
      end
      if (any_err) begin
        state    <= SEARCH;
        acc      <= '0;
        frame_ok <= 1'b0;
        err_flags[ERR_HSW]   <= err_flags[ERR_HSW] | hsw_err;
        err_flags[ERR_LINE]  <= err_flags[ERR_LINE] | line_err;
        err_flags[ERR_FRAME] <= err_flags[ERR_FRAME] | frame_err;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end else if (vs_start) begin
        acc <= '0;
        if (state == SEARCH) begin
          state <= ACQUIRE;
        end else begin
          state          <= LOCKED;
          frame_checksum <= acc;
          frame_ok       <= 1'b1;
        end
      end else if (vis) begin
        acc <= acc + {12'd0, vgaRGB};
      end
    end
  end

endmodule
